// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter (ALU vs LSU) onto the register file write port,
// with a per-register busy scoreboard; optional counters via REGFILE_WB_PERF_EN.
module regfile_wb_arbiter #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    output logic                  rs1_busy,
    output logic                  rs2_busy,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [ADDR_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0] alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [ADDR_WIDTH-1:0] lsu_rd,
    input  logic [DATA_WIDTH-1:0] lsu_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_rd,
    output logic [DATA_WIDTH-1:0] rf_dataD
`ifdef REGFILE_WB_PERF_EN
    ,
    output logic [31:0]           perf_conflict_cnt,
    output logic [31:0]           perf_write_cnt
`endif
);

    localparam int NREG = 1 << ADDR_WIDTH;

    logic [NREG-1:0]       r_busy;
    logic                  r_pref_lsu;
    logic                  r_wen;
    logic [ADDR_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_data;

    logic                  w_grant_alu;
    logic                  w_grant_lsu;
    logic                  w_grant;
    logic [ADDR_WIDTH-1:0] w_grant_rd;
    logic [DATA_WIDTH-1:0] w_grant_data;
    logic                  w_issue_fire;
    logic [NREG-1:0]       w_busy_nxt;

    always_comb begin
        w_grant_alu = 1'b0;
        w_grant_lsu = 1'b0;
        if (!rst) begin
            if (alu_valid && lsu_valid) begin
                w_grant_alu = !r_pref_lsu;
                w_grant_lsu = r_pref_lsu;
            end else begin
                w_grant_alu = alu_valid;
                w_grant_lsu = lsu_valid;
            end
        end
    end

    assign w_grant      = w_grant_alu | w_grant_lsu;
    assign w_grant_rd   = w_grant_lsu ? lsu_rd : alu_rd;
    assign w_grant_data = w_grant_lsu ? lsu_data : alu_data;

    assign alu_ready    = w_grant_alu;
    assign lsu_ready    = w_grant_lsu;
    assign rs1_busy     = r_busy[rs1];
    assign rs2_busy     = r_busy[rs2];
    assign issue_ready  = !r_busy[issue_rd] || (issue_rd == '0);
    assign w_issue_fire = issue_valid && issue_ready && (issue_rd != '0);

    // Set is applied after clear so a same-edge issue wins over retirement
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_grant) begin
            w_busy_nxt[w_grant_rd] = 1'b0;
        end
        if (w_issue_fire) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy     <= '0;
            r_pref_lsu <= 1'b0;
            r_wen      <= 1'b0;
            r_rd       <= '0;
            r_data     <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            r_wen  <= w_grant && (w_grant_rd != '0);
            if (w_grant) begin
                r_pref_lsu <= w_grant_alu;
                r_rd       <= w_grant_rd;
                r_data     <= w_grant_data;
            end
        end
    end

    assign rf_wen   = r_wen;
    assign rf_rd    = r_rd;
    assign rf_dataD = r_data;

`ifdef REGFILE_WB_PERF_EN
    logic [31:0] r_conflict_cnt;
    logic [31:0] r_write_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_conflict_cnt <= '0;
            r_write_cnt    <= '0;
        end else begin
            if (alu_valid && lsu_valid) begin
                r_conflict_cnt <= r_conflict_cnt + 32'd1;
            end
            if (w_grant && (w_grant_rd != '0)) begin
                r_write_cnt <= r_write_cnt + 32'd1;
            end
        end
    end

    assign perf_conflict_cnt = r_conflict_cnt;
    assign perf_write_cnt    = r_write_cnt;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomized self-checking bench for regfile_wb_arbiter against a behavioural model.
module tb_regfile_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          issue_ready;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          rs1_busy;
    logic          rs2_busy;
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_rd;
    logic [DW-1:0] alu_data;
    logic          lsu_valid;
    logic          lsu_ready;
    logic [AW-1:0] lsu_rd;
    logic [DW-1:0] lsu_data;
    logic          rf_wen;
    logic [AW-1:0] rf_rd;
    logic [DW-1:0] rf_dataD;
`ifdef REGFILE_WB_PERF_EN
    logic [31:0]   perf_conflict_cnt;
    logic [31:0]   perf_write_cnt;
`endif

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .issue_ready(issue_ready),
        .rs1(rs1), .rs2(rs2),
        .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready),
        .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_dataD(rf_dataD)
`ifdef REGFILE_WB_PERF_EN
        ,
        .perf_conflict_cnt(perf_conflict_cnt),
        .perf_write_cnt(perf_write_cnt)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    bit            m_busy [32];
    bit            m_last_lsu;
    bit            m_wen;
    logic [AW-1:0] m_rd;
    logic [DW-1:0] m_data;
    bit            m_chk_all;
    int unsigned   m_conf;
    int unsigned   m_wr;
    bit            last_ga;
    bit            last_gl;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Call at posedge+1 with inputs driven; returns at next posedge+1
    task automatic step();
        bit            ga;
        bit            gl;
        bit            ir;
        logic [AW-1:0] grd;
        #1;
        ga = 1'b0;
        gl = 1'b0;
        if (!rst) begin
            if (alu_valid && lsu_valid) begin
                ga = m_last_lsu;
                gl = !m_last_lsu;
            end else begin
                ga = alu_valid;
                gl = lsu_valid;
            end
        end
        ir = (issue_rd == 0) || !m_busy[issue_rd];
        chk("alu_ready", alu_ready, ga);
        chk("lsu_ready", lsu_ready, gl);
        chk("issue_ready", issue_ready, ir);
        chk("rs1_busy", rs1_busy, m_busy[rs1]);
        chk("rs2_busy", rs2_busy, m_busy[rs2]);
        last_ga = ga;
        last_gl = gl;
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 1'b0;
            m_last_lsu = 1'b1;
            m_wen = 1'b0;
            m_rd = '0;
            m_data = '0;
            m_chk_all = 1'b1;
            m_conf = 0;
            m_wr = 0;
        end else begin
            m_chk_all = 1'b0;
            m_wen = 1'b0;
            if (alu_valid && lsu_valid) m_conf++;
            if (ga || gl) begin
                grd = ga ? alu_rd : lsu_rd;
                m_busy[grd] = 1'b0;
                m_last_lsu = gl;
                m_wen = (grd != 0);
                m_rd = grd;
                m_data = ga ? alu_data : lsu_data;
                if (grd != 0) m_wr++;
            end
            if (issue_valid && ir && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("rf_wen", rf_wen, m_wen);
        if (m_wen || m_chk_all) begin
            chk("rf_rd", rf_rd, m_rd);
            chk("rf_dataD", rf_dataD, m_data);
        end
`ifdef REGFILE_WB_PERF_EN
        chk("perf_conflict", perf_conflict_cnt, m_conf);
        chk("perf_write", perf_write_cnt, m_wr);
`endif
    endtask

    task automatic idle();
        rst = 1'b0;
        issue_valid = 1'b0;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        issue_rd = '0; rs1 = '0; rs2 = '0;
        alu_rd = '0; alu_data = '0; lsu_rd = '0; lsu_data = '0;
        m_last_lsu = 1'b1;
        @(posedge clk);
        #1;
        do_reset();
        rs1 = 5'd3; rs2 = 5'd17;
        step();

        // Single ALU write
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h1234;
        step();
        chk("alu5_wen", rf_wen, 1'b1);
        chk("alu5_rd", rf_rd, 5'd5);
        chk("alu5_data", rf_dataD, 64'h1234);
        idle();

        // Alternating grants under contention
        do_reset();
        alu_rd = 5'd3; lsu_rd = 5'd4;
        for (int i = 0; i < 4; i++) begin
            alu_valid = 1'b1; lsu_valid = 1'b1;
            alu_data = 64'(100 + i); lsu_data = 64'(200 + i);
            step();
            chk("rr_rd", rf_rd, (i % 2 == 0) ? 5'd3 : 5'd4);
        end
        idle();

        // WAW stall and release on x7
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0; rs1 = 5'd7;
        step();
        chk("x7_busy", rs1_busy, 1'b1);
        issue_valid = 1'b1;
        #1 chk("x7_stall", issue_ready, 1'b0);
        #1;
        @(posedge clk); #1;
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 64'hdead_beef;
        #1 chk("x7_busy_pre", rs1_busy, 1'b1);
        #1;
        @(posedge clk); #1;
        m_busy[7] = 1'b0;
        m_wen = 1'b1; m_rd = 5'd7; m_data = 64'hdead_beef;
        m_last_lsu = 1'b0;
        chk("x7_wb", rf_rd, 5'd7);
        alu_valid = 1'b0;
        issue_valid = 1'b1; issue_rd = 5'd7;
        step();
        issue_valid = 1'b0;

        // Same-edge issue and retire of x9
        do_reset();
        issue_valid = 1'b1; issue_rd = 5'd9;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 64'h99;
        step();
        idle(); rs2 = 5'd9;
        step();
        chk("x9_busy", rs2_busy, 1'b1);

        // x0 handling
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 64'h55;
        step();
        chk("x0_wen", rf_wen, 1'b0);
        idle();
        issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
        step();
        chk("x0_busy", rs1_busy, 1'b0);
        idle();

`ifdef REGFILE_WB_PERF_EN
        do_reset();
        alu_valid = 1'b1; alu_rd = 5'd1; lsu_valid = 1'b1; lsu_rd = 5'd2;
        step();
        alu_rd = 5'd0;
        step();
        lsu_rd = 5'd3;
        step();
        alu_valid = 1'b0;
        step();
        lsu_valid = 1'b0;
        chk("perf_conf3", perf_conflict_cnt, 32'd3);
        chk("perf_wr3", perf_write_cnt, 32'd3);
        issue_valid = 1'b1; issue_rd = 5'd12; alu_valid = 1'b1;
        alu_rd = 5'd6;
        step();
        do_reset();
        rs1 = 5'd12;
        step();
        chk("perf_rst_c", perf_conflict_cnt, 32'd0);
        chk("perf_rst_w", perf_write_cnt, 32'd0);
        chk("rst_busy", rs1_busy, 1'b0);
`endif

        // Randomized traffic with occasional reset
        idle();
        last_ga = 1'b0; last_gl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (rst) begin
                alu_valid = 1'b0;
                lsu_valid = 1'b0;
            end else begin
                if (!alu_valid || last_ga) begin
                    alu_valid = ($urandom_range(0, 2) != 0);
                    alu_rd = AW'($urandom);
                    alu_data = {$urandom, $urandom};
                end
                if (!lsu_valid || last_gl) begin
                    lsu_valid = ($urandom_range(0, 2) != 0);
                    lsu_rd = AW'($urandom);
                    lsu_data = {$urandom, $urandom};
                end
            end
            issue_valid = $urandom_range(0, 1) != 0;
            issue_rd = AW'($urandom);
            rs1 = AW'($urandom);
            rs2 = AW'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
